uart_tx_fifo: RTL
=================

# uart_tx_fifo

Buffered UART transmitter: the transmit-side counterpart to the board UART receiver, serialising N-bit words onto a single line as start bit, N data bits LSB first, and STOP_BITS stop bits, with no parity. Words enter through a valid/ready handshake into a small FIFO, so host logic can queue several bytes without waiting on the line. The block sits between on-board command/response logic and the FPGA TX pin, and shares the receiver's bit-timing parameters so both ends run at the same rate.

## Interface
- N, 8, data bits per frame (5..9)
- PSCALER, 1, clock prescaler, ≥1
- DIV, 10, prescaled ticks per bit, ≥1; bit period BIT = PSCALER*DIV sysclk cycles
- DEPTH, 4, FIFO entries, power of two ≥2
- STOP_BITS, 1, stop bits per frame (1 or 2)
- sysclk  in  1  system clock; all logic is on the rising edge
- reset  in  1  asynchronous, active-high reset
- data_i  in  N  word to transmit
- valid_i  in  1  data_i is valid
- ready_o  out  1  FIFO can accept a word (= count_o < DEPTH)
- tx_o  out  1  serial line, idle high
- busy_o  out  1  a frame is in progress (state ≠ IDLE)
- count_o  out  $clog2(DEPTH+1)  words queued, not counting the frame in flight

## Operation
- Push: on a rising edge with valid_i && ready_o, data_i is written and count_o increments.
- No bypass: a word is always written to the FIFO before it is transmitted.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx_o=1. If count_o>0, pop the head into shift register sh, load the bit timer, and go to START.
- START: tx_o=0 for BIT cycles, then go to DATA with bit index 0.
- DATA: tx_o=sh[0] for BIT cycles, then shift right. After the N-th bit, go to STOP.
- STOP: tx_o=1 for STOP_BITS*BIT cycles. At the end of STOP:
  - count_o>0: pop immediately and go to START, so frames are back-to-back with no extra idle cycle.
  - otherwise: go to IDLE.
- Bit timer is a prescaler counter (0..PSCALER-1) feeding a tick counter (0..DIV-1); a bit ends when both wrap together.
- Simultaneous push and pop: count_o is unchanged, and both pointers advance.
- Push while full: impossible, because ready_o=0. valid_i is ignored; no overwrite.
- Pointers are log2(DEPTH) bits wide and wrap naturally; count_o tracks fullness.

## Timing
- Reset values (asserted asynchronously, immediately): tx_o=1, busy_o=0, ready_o=1, count_o=0, FSM=IDLE, FIFO flushed, timers cleared.
- Reset mid-frame aborts the frame; tx_o returns high without waiting for a clock.
- tx_o, busy_o and count_o are registered. ready_o is decoded combinationally from the registered count.
- Latency with the block idle and the FIFO empty:
  - push accepted at edge k → IDLE sees the word at edge k+1;
  - tx_o falls and busy_o rises after edge k+1.
- Frame length is exactly (1+N+STOP_BITS)*BIT cycles; every bit holds for exactly BIT cycles.
- busy_o falls after the last STOP cycle, when returning to IDLE.
- busy_o stays high across back-to-back frames.
- count_o decrements at the pop edge, which is the same edge at which tx_o falls for the start bit.

## Test plan
- Reset: hold reset high → tx_o=1, ready_o=1, count_o=0, busy_o=0. Release reset with no pushes → tx_o stays 1 for 200 cycles.
- Single frame, defaults (BIT=10): push 0xA5 at edge k. Required tx_o, 10 cycles per bit, from edge k+1:
  - start bit 0;
  - data bits 1,0,1,0,0,1,0,1;
  - stop bit 1.
  - busy_o high for exactly 100 cycles.
- Back-to-back: push 0x00 then 0xFF on consecutive edges → two 100-cycle frames with no idle gap. The second start bit begins on the cycle after the first stop ends. count_o reads 1 then 0.
- FIFO full: push 6 words on consecutive edges while the first frame starts → ready_o=0 once count_o=4. Exactly 5 words are accepted and transmitted in order; the 6th is never sent.
- Parameter corner: PSCALER=2, DIV=3, STOP_BITS=2, push 0x01 → BIT=6. Frame is 66 cycles, and the final stop high period is 12 cycles.
- Reset mid-frame: assert reset during data bit 3 → tx_o goes to 1 asynchronously, and count_o and busy_o go to 0. After release, a new push of 0x3C produces a clean frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Words are queued through a valid/ready handshake into a small FIFO, then
// serialised as start bit, N data bits LSB first and STOP_BITS stop bits.
// tx_o, busy_o and count_o are registered; ready_o decodes the registered count.
module uart_tx_fifo #(
    parameter int N         = 8,
    parameter int PSCALER   = 1,
    parameter int DIV       = 10,
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic                         sysclk,
    input  logic                         reset,
    input  logic [N-1:0]                 data_i,
    input  logic                         valid_i,
    output logic                         ready_o,
    output logic                         tx_o,
    output logic                         busy_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    // Field widths; single-value counters still get one bit so they exist.
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = (PSCALER > 1) ? $clog2(PSCALER) : 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int BW = $clog2(N + 1);

    localparam logic [PW-1:0] PRE_LAST  = PW'(PSCALER - 1);
    localparam logic [DW-1:0] TICK_LAST = DW'(DIV - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(N - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // FIFO storage and bookkeeping
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    // Transmit engine
    state_t        state_reg;
    state_t        state_next;
    logic [N-1:0]  sh_reg;
    logic [N-1:0]  sh_next;
    logic [BW-1:0] bit_reg;
    logic [BW-1:0] bit_next;
    logic [PW-1:0] pre_reg;
    logic [PW-1:0] pre_next;
    logic [DW-1:0] tick_reg;
    logic [DW-1:0] tick_next;

    // Registered line outputs
    logic          tx_reg;
    logic          tx_next;
    logic          busy_reg;
    logic          busy_next;

    logic          push;
    logic          pop;
    logic          bit_end;
    logic          queued;

    assign ready_o = (count_reg != FULL);
    assign push    = valid_i && ready_o;
    assign queued  = (count_reg != '0);
    // A bit period ends when the prescaler and tick counter wrap together.
    assign bit_end = (pre_reg == PRE_LAST) && (tick_reg == TICK_LAST);

    assign tx_o    = tx_reg;
    assign busy_o  = busy_reg;
    assign count_o = count_reg;

    // FIFO write port; contents need no reset because the pointers are flushed.
    always_ff @(posedge sysclk) begin
        if (push) begin
            mem[wr_ptr_reg] <= data_i;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

    // Occupancy update; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Bit timer: held at zero while idle so every frame starts on a fresh bit.
    always_comb begin
        pre_next  = '0;
        tick_next = '0;
        if (state_reg != IDLE) begin
            if (pre_reg == PRE_LAST) begin
                pre_next  = '0;
                tick_next = (tick_reg == TICK_LAST) ? '0 : tick_reg + DW'(1);
            end else begin
                pre_next  = pre_reg + PW'(1);
                tick_next = tick_reg;
            end
        end
    end

    // State register with the shift register, bit index, timer and outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_reg <= IDLE;
            sh_reg    <= '0;
            bit_reg   <= '0;
            pre_reg   <= '0;
            tick_reg  <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            sh_reg    <= sh_next;
            bit_reg   <= bit_next;
            pre_reg   <= pre_next;
            tick_reg  <= tick_next;
            tx_reg    <= tx_next;
            busy_reg  <= busy_next;
        end
    end

    // Next-state logic: frame sequencing and FIFO pops.
    always_comb begin
        state_next = state_reg;
        pop        = 1'b0;
        sh_next    = sh_reg;
        bit_next   = bit_reg;
        case (state_reg)
            IDLE: begin
                if (queued) begin
                    pop        = 1'b1;
                    sh_next    = mem[rd_ptr_reg];
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    bit_next   = '0;
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    sh_next = sh_reg >> 1;
                    if (bit_reg == DATA_LAST) begin
                        bit_next   = '0;
                        state_next = STOP;
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (bit_reg == STOP_LAST) begin
                        bit_next = '0;
                        // Chain straight into the next frame when one is queued.
                        if (queued) begin
                            pop        = 1'b1;
                            sh_next    = mem[rd_ptr_reg];
                            state_next = START;
                        end else begin
                            state_next = IDLE;
                        end
                    end else begin
                        bit_next = bit_reg + BW'(1);
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered line is cycle-exact.
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = sh_next[0];
            default: tx_next = 1'b1;
        endcase
    end

endmodule
